// File: rtl/multi_chn_frame_pkg.sv
// Shared types and helpers for the multi-channel ADC frame multiplexer.
package multi_chn_frame_pkg;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_FRAME  = 1'b1;

    localparam logic [15:0] DEF_HDR_WORD = 16'hEB90;

    // Channel scan helpers are sized for the largest supported channel count.
    localparam int unsigned MAX_CHN = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } frame_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } chn_pick_t;

    // Lowest enabled channel at or above start; valid=0 when none remain.
    function automatic chn_pick_t next_en_idx(input logic [MAX_CHN-1:0] mask,
                                              input int                 start);
        chn_pick_t pick;
        pick = '0;
        for (int i = int'(MAX_CHN) - 1; i >= 0; i--) begin
            if (i >= start && mask[i]) begin
                pick.valid = 1'b1;
                pick.idx   = IDX_W'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/multi_chn_frame_mux_buf.sv
// Per-channel sample FIFO with first-word-fall-through read data.
// A word becomes visible to the reader one edge after it is written, which
// sets the two-edge write-to-emit latency through the registered output.
module chn_sample_buf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              fresh;
    logic              push_ok_c;
    logic              pop_ok_c;

    // Occupancy flags; the word written on the last edge is not yet readable.
    assign full      = (cnt == CNT_W'(DEPTH));
    assign empty     = (cnt == CNT_W'(fresh));
    assign dout      = mem[rd_ptr];
    assign push_ok_c = push && (!full || pop);
    assign pop_ok_c  = pop && !empty;

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (!flush && push_ok_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the just-written marker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            fresh  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            fresh  <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt   <= cnt + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
            fresh <= push_ok_c;
        end
    end

endmodule

// File: rtl/multi_chn_frame_mux.sv
// Buffers NUM_CHN ADC streams and emits one channel or header-tagged frames
// toward the USB slave FIFO, honouring downstream backpressure.
module multi_chn_frame_mux
    import multi_chn_frame_pkg::*;
#(
    parameter int unsigned       NUM_CHN   = 4,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       BUF_DEPTH = 8,
    parameter logic [DATA_W-1:0] HDR_WORD  = DATA_W'(DEF_HDR_WORD)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        mode,
    input  logic [$clog2(NUM_CHN)-1:0]  chn_sel,
    input  logic [NUM_CHN-1:0]          chn_en,
    input  logic [NUM_CHN*DATA_W-1:0]   din,
    input  logic [NUM_CHN-1:0]          din_en,
    input  logic                        dout_full,
    output logic [DATA_W-1:0]           dout,
    output logic                        dout_en,
    output logic [NUM_CHN-1:0]          ovf_flag,
    input  logic                        ovf_clr,
    output logic [15:0]                 frame_cnt
);

    localparam int unsigned SEL_W = $clog2(NUM_CHN);

    frame_state_e       state, state_n;
    logic [SEL_W-1:0]   idx, idx_n;
    logic [NUM_CHN-1:0] en_lat, en_lat_n;
    logic [DATA_W-1:0]  dout_n;
    logic               dout_en_n;
    logic               frame_done_c;
    logic               pop_any_c;
    logic [SEL_W-1:0]   pop_idx_c;

    logic [NUM_CHN-1:0] pop_c;
    logic [NUM_CHN-1:0] buf_empty;
    logic [NUM_CHN-1:0] buf_full;
    logic [NUM_CHN-1:0] ovf_set_c;
    logic [DATA_W-1:0]  buf_dout [NUM_CHN];

    logic               sel_empty_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic [DATA_W-1:0]  idx_data_c;
    logic               all_ready_c;
    chn_pick_t          first_pick_c;
    chn_pick_t          next_pick_c;

    // One buffer per channel; overflow only when a full buffer is not popped.
    for (genvar g = 0; g < NUM_CHN; g++) begin : g_chn
        assign pop_c[g]     = pop_any_c && (pop_idx_c == SEL_W'(g));
        assign ovf_set_c[g] = din_en[g] && buf_full[g] && !pop_c[g] && !flush;

        chn_sample_buf #(
            .DATA_W (DATA_W),
            .DEPTH  (BUF_DEPTH)
        ) u_buf (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .push    (din_en[g]),
            .pop     (pop_c[g]),
            .din     (din[g*DATA_W +: DATA_W]),
            .dout    (buf_dout[g]),
            .empty   (buf_empty[g]),
            .full    (buf_full[g])
        );
    end

    // Channel read muxes for the single-channel selection and frame index.
    always_comb begin
        sel_empty_c = 1'b1;
        sel_data_c  = '0;
        idx_data_c  = '0;
        for (int i = 0; i < int'(NUM_CHN); i++) begin
            if (chn_sel == SEL_W'(i)) begin
                sel_empty_c = buf_empty[i];
                sel_data_c  = buf_dout[i];
            end
            if (idx == SEL_W'(i)) begin
                idx_data_c = buf_dout[i];
            end
        end
    end

    assign all_ready_c  = &(~buf_empty | ~chn_en);
    assign first_pick_c = next_en_idx(MAX_CHN'(en_lat), 0);
    assign next_pick_c  = next_en_idx(MAX_CHN'(en_lat), int'(idx) + 1);

    // Next-state, pop and output-word decision.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        en_lat_n     = en_lat;
        dout_n       = dout;
        dout_en_n    = 1'b0;
        frame_done_c = 1'b0;
        pop_any_c    = 1'b0;
        pop_idx_c    = idx;

        case (state)
            IDLE: begin
                if (mode == MODE_SINGLE) begin
                    if (!sel_empty_c && !dout_full) begin
                        pop_any_c = 1'b1;
                        pop_idx_c = chn_sel;
                        dout_n    = sel_data_c;
                        dout_en_n = 1'b1;
                    end
                end else if ((chn_en != '0) && all_ready_c && !dout_full) begin
                    en_lat_n = chn_en;
                    state_n  = HEADER;
                end
            end
            HEADER: begin
                if (!dout_full) begin
                    dout_n    = HDR_WORD;
                    dout_en_n = 1'b1;
                    state_n   = DATA;
                    if (first_pick_c.valid) begin
                        idx_n = SEL_W'(first_pick_c.idx);
                    end
                end
            end
            DATA: begin
                if (!dout_full) begin
                    pop_any_c = 1'b1;
                    pop_idx_c = idx;
                    dout_n    = idx_data_c;
                    dout_en_n = 1'b1;
                    if (next_pick_c.valid) begin
                        idx_n = SEL_W'(next_pick_c.idx);
                    end else begin
                        frame_done_c = 1'b1;
                        state_n      = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Flush abandons any frame in progress without counting it.
        if (flush) begin
            state_n      = IDLE;
            dout_en_n    = 1'b0;
            pop_any_c    = 1'b0;
            frame_done_c = 1'b0;
        end
    end

    // FSM state and registered output word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            en_lat  <= '0;
            dout    <= '0;
            dout_en <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            en_lat  <= en_lat_n;
            dout    <= dout_n;
            dout_en <= dout_en_n;
        end
    end

    // Completed-frame counter and sticky overflow flags; a new overflow beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            ovf_flag  <= '0;
        end else begin
            frame_cnt <= frame_cnt + 16'(frame_done_c);
            ovf_flag  <= (ovf_clr ? '0 : ovf_flag) | ovf_set_c;
        end
    end

endmodule

// File: tb/tb_multi_chn_frame_mux.sv
// Self-checking bench for multi_chn_frame_mux: directed scenarios followed by
// randomized phases compared against a queue-level stream model.
module tb_multi_chn_frame_mux;
    import multi_chn_frame_pkg::*;

    localparam logic [15:0] HDR = 16'hEB90;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  chn_sel = '0;
    logic [3:0]  chn_en = '0;
    logic [63:0] din = '0;
    logic [3:0]  din_en = '0;
    logic        dout_full = 1'b0;
    logic [15:0] dout;
    logic        dout_en;
    logic [3:0]  ovf_flag;
    logic        ovf_clr = 1'b0;
    logic [15:0] frame_cnt;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] got [$];
    logic        full_q = 1'b0;
    logic [15:0] vals [4][8];
    int          nv [4];
    int          ptr [4];

    multi_chn_frame_mux dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .mode      (mode),
        .chn_sel   (chn_sel),
        .chn_en    (chn_en),
        .din       (din),
        .din_en    (din_en),
        .dout_full (dout_full),
        .dout      (dout),
        .dout_en   (dout_en),
        .ovf_flag  (ovf_flag),
        .ovf_clr   (ovf_clr),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Backpressure seen by the deciding edge.
    always @(posedge clk) full_q <= dout_full;

    // Capture every emitted word; none may follow an edge that saw dout_full.
    always @(negedge clk) begin
        if (dout_en) begin
            got.push_back(dout);
            check("no_write_when_full", 32'(full_q), 32'(0));
        end
    end

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 6 && n < 400) begin
            @(negedge clk);
            n++;
            if (dout_en) quiet = 0;
            else quiet++;
        end
        check({tag, "_drain"}, 32'(quiet >= 6), 32'(1));
    endtask

    task automatic wait_hdr(input string tag);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < 50) begin
            @(negedge clk);
            n++;
            if (dout_en && dout == HDR) found = 1'b1;
        end
        check({tag, "_hdr_seen"}, 32'(found), 32'(1));
    endtask

    task automatic check_stream(input string tag, input logic [15:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_q [$];
        int          fc_exp;

        // Reset state
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_dout_en", 32'(dout_en), 32'(0));
        check("rst_ovf", 32'(ovf_flag), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Single-channel mode, latency and order
        mode = MODE_SINGLE; chn_sel = 2'd2;
        din[32 +: 16] = 16'h0100; din_en = 4'b0100;
        @(negedge clk); check("lat_edge1", 32'(dout_en), 32'(0)); din[32 +: 16] = 16'h0101;
        @(negedge clk); check("lat_edge2", 32'(dout_en), 32'(0)); din[32 +: 16] = 16'h0102;
        @(negedge clk); check("lat_edge3", 32'({dout_en, dout}), 32'({1'b1, 16'h0100}));
        din[32 +: 16] = 16'h0103;
        @(negedge clk); din[32 +: 16] = 16'h0104;
        @(negedge clk); din_en = '0;
        wait_idle("m0");
        exp_q = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
        check_stream("m0", exp_q); got.delete();

        // One frame over channels 0, 1, 3
        mode = MODE_FRAME; chn_en = 4'b1011;
        din = {16'hA003, 16'h0000, 16'hA001, 16'hA000}; din_en = 4'b1011;
        @(negedge clk); din_en = '0;
        wait_idle("f1");
        exp_q = '{HDR, 16'hA000, 16'hA001, 16'hA003};
        check_stream("f1", exp_q); got.delete();
        fc_exp = 1;
        check("f1_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
        mode = MODE_SINGLE; chn_sel = 2'd2;
        wait_idle("ch2");
        check("ch2_untouched", 32'(got.size()), 32'(0));

        // Backpressure for three cycles right after the header
        mode = MODE_FRAME; chn_en = 4'b1011;
        din = {16'hB003, 16'h0000, 16'hB001, 16'hB000}; din_en = 4'b1011;
        @(negedge clk); din_en = '0;
        wait_hdr("stall");
        dout_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_c%0d", i), 32'(dout_en), 32'(0));
        end
        dout_full = 1'b0;
        wait_idle("stall");
        exp_q = '{HDR, 16'hB000, 16'hB001, 16'hB003};
        check_stream("stall", exp_q); got.delete();
        fc_exp = 2;
        check("stall_frame_cnt", 32'(frame_cnt), 32'(fc_exp));

        // Overflow on channel 1, clear, and set-beats-clear
        mode = MODE_SINGLE; chn_sel = 2'd0;
        for (int i = 0; i < 9; i++) begin
            din[16 +: 16] = 16'hC000 + 16'(i); din_en = 4'b0010;
            @(negedge clk);
            if (i == 7) check("ovf_at_full", 32'(ovf_flag), 32'(0));
        end
        din_en = '0;
        check("ovf_set", 32'(ovf_flag), 32'(4'b0010));
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf_flag), 32'(0));
        din[16 +: 16] = 16'hC0FF; din_en = 4'b0010; ovf_clr = 1'b1;
        @(negedge clk); din_en = '0; ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(ovf_flag), 32'(4'b0010));
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check("ovf_clr2", 32'(ovf_flag), 32'(0));
        chn_sel = 2'd1;
        wait_idle("ovf");
        exp_q = '{};
        for (int i = 0; i < 8; i++) exp_q.push_back(16'hC000 + 16'(i));
        check_stream("ovf", exp_q); got.delete();

        // Flush after the header
        mode = MODE_FRAME; chn_en = 4'b1111;
        din = {16'hD003, 16'hD002, 16'hD001, 16'hD000}; din_en = 4'b1111;
        @(negedge clk); din_en = '0;
        wait_hdr("fl");
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        check("flush_dout_en", 32'(dout_en), 32'(0));
        wait_idle("fl");
        exp_q = '{HDR};
        check_stream("fl", exp_q); got.delete();
        check("flush_frame_cnt", 32'(frame_cnt), 32'(fc_exp));

        // Settings change inside a frame apply from the next IDLE
        mode = MODE_FRAME; chn_en = 4'b0011;
        din = {16'h0000, 16'hE012, 16'hE001, 16'hE000}; din_en = 4'b0111;
        @(negedge clk); din_en = '0;
        wait_hdr("chg");
        mode = MODE_SINGLE; chn_sel = 2'd2; chn_en = 4'b1111;
        wait_idle("chg");
        exp_q = '{HDR, 16'hE000, 16'hE001, 16'hE012};
        check_stream("chg", exp_q); got.delete();
        fc_exp = 3;
        check("chg_frame_cnt", 32'(frame_cnt), 32'(fc_exp));

        // Randomized phases against the stream model
        for (int ph = 0; ph < 6; ph++) begin
            logic [3:0] mask;
            int         sel;
            int         k;
            bit         busy;
            flush = 1'b1; @(negedge clk); flush = 1'b0;
            got.delete();
            mask = 4'($urandom_range(1, 15));
            sel  = int'($urandom_range(0, 3));
            k    = int'($urandom_range(1, 5));
            for (int c = 0; c < 4; c++) begin
                if (ph % 2 == 1) nv[c] = mask[c] ? k : int'($urandom_range(0, 6));
                else             nv[c] = int'($urandom_range(1, 8));
                ptr[c] = 0;
                for (int j = 0; j < 8; j++) vals[c][j] = 16'($urandom);
            end
            mode = (ph % 2 == 1) ? MODE_FRAME : MODE_SINGLE;
            chn_sel = 2'(sel); chn_en = mask;
            busy = 1'b1;
            while (busy) begin
                busy = 1'b0; din_en = '0;
                for (int c = 0; c < 4; c++) begin
                    if (ptr[c] < nv[c]) begin
                        busy = 1'b1;
                        if ($urandom_range(0, 1) == 1) begin
                            din[c*16 +: 16] = vals[c][ptr[c]];
                            din_en[c] = 1'b1;
                            ptr[c]++;
                        end
                    end
                end
                dout_full = ($urandom_range(0, 2) == 0);
                @(negedge clk);
            end
            din_en = '0; dout_full = 1'b0;
            wait_idle($sformatf("rnd%0d", ph));
            exp_q = '{};
            if (ph % 2 == 1) begin
                for (int f = 0; f < k; f++) begin
                    exp_q.push_back(HDR);
                    for (int c = 0; c < 4; c++) if (mask[c]) exp_q.push_back(vals[c][f]);
                end
                fc_exp += k;
            end else begin
                for (int j = 0; j < nv[sel]; j++) exp_q.push_back(vals[sel][j]);
            end
            check_stream($sformatf("rnd%0d", ph), exp_q); got.delete();
            check($sformatf("rnd%0d_frame_cnt", ph), 32'(frame_cnt), 32'(fc_exp));
            check($sformatf("rnd%0d_ovf", ph), 32'(ovf_flag), 32'(0));
        end

        // Asynchronous reset in the middle of a frame
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        mode = MODE_FRAME; chn_en = 4'b1111;
        din = {16'hF003, 16'hF002, 16'hF001, 16'hF000}; din_en = 4'b1111;
        @(negedge clk); din_en = '0;
        wait_hdr("arst");
        #2 reset_n = 1'b0;
        #1;
        check("arst_dout", 32'(dout), 32'(0));
        check("arst_dout_en", 32'(dout_en), 32'(0));
        check("arst_frame_cnt", 32'(frame_cnt), 32'(0));
        check("arst_ovf", 32'(ovf_flag), 32'(0));
        @(negedge clk); reset_n = 1'b1;
        got.delete();
        repeat (10) @(negedge clk);
        check("arst_no_partial", 32'(got.size()), 32'(0));
        check("arst_frame_cnt_hold", 32'(frame_cnt), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_chn_frame_mux.md
Name: multi_chn_frame_mux

Overview:
- Parametrised successor to the two-channel ADC FIFO control stage.
- Accepts NUM_CHN independent ADC sample streams, each a data word plus a one-cycle valid strobe, and buffers each stream in a small per-channel FIFO.
- Emits either a single selected channel or header-tagged interleaved frames toward the USB external FIFO, with backpressure and per-channel overflow reporting.
- Sits between the AD7985 channel controllers and the USB slave-FIFO data path.

Parameters:
- NUM_CHN, 4, number of ADC input channels (2..8).
- DATA_W, 16, sample and output word width.
- BUF_DEPTH, 8, per-channel buffer depth in words (power of 2, >=2).
- HDR_WORD, 16'hEB90, frame header word emitted in interleave mode.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all buffers and the FSM.
- mode  in  1  0 = single channel, 1 = frame interleave.
- chn_sel  in  clog2(NUM_CHN)  channel used in mode 0.
- chn_en  in  NUM_CHN  channel enable mask used in mode 1.
- din  in  NUM_CHN*DATA_W  packed samples; channel i occupies bits [i*DATA_W +: DATA_W].
- din_en  in  NUM_CHN  per-channel sample-valid strobe.
- dout_full  in  1  downstream FIFO full/prog-full; no write is allowed while high.
- dout  out  DATA_W  output word.
- dout_en  out  1  write strobe to the downstream FIFO.
- ovf_flag  out  NUM_CHN  sticky per-channel overflow flag.
- ovf_clr  in  1  clears all ovf_flag bits.
- frame_cnt  out  16  count of completed frames (mode 1), wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (reset_n low, asynchronous): all buffers empty, FSM in IDLE, dout=0, dout_en=0, ovf_flag=0, frame_cnt=0.
- Buffer write:
  - din_en[i] high at a clock edge writes din slice i into buffer i, unless the buffer is full.
  - Earliest dout_en for that sample is the 2nd clock edge after the write edge.
- Overflow:
  - din_en[i] while buffer i is full (with no simultaneous pop) drops the sample and sets ovf_flag[i].
  - Pop and push in the same cycle on a full buffer: push accepted, count unchanged, no overflow.
  - ovf_clr clears all flags; a set event in the same cycle wins for that bit.
- Output registers: dout and dout_en are registered. dout_en is high only in a cycle whose preceding decision edge saw dout_full=0. A word is popped only when it is emitted, so no word is ever lost to backpressure.
- FSM states: IDLE, HEADER, DATA.
- IDLE:
  - mode, chn_sel and chn_en are latched here only; changes mid-frame take effect at the next IDLE.
  - Mode 0: if buffer[chn_sel] is non-empty and dout_full=0, pop it and emit. FSM stays in IDLE, giving one word per cycle of sustained throughput.
  - Mode 1: if chn_en!=0, every enabled buffer is non-empty and dout_full=0, go to HEADER.
  - Mode 1 with chn_en==0: stay in IDLE and emit nothing. Buffers keep filling and may overflow.
- HEADER:
  - Emit HDR_WORD if dout_full=0, then go to DATA with the index at the lowest enabled channel.
  - If dout_full=1, stall in HEADER with dout_en=0.
- DATA:
  - Pop and emit the buffer at the current index when dout_full=0, then advance to the next higher enabled channel.
  - After the highest enabled channel: frame_cnt+1, return to IDLE.
  - A back-to-back frame may start on the next cycle, so each frame costs 1 + popcount(chn_en) output words plus one IDLE cycle.
  - Stall when dout_full=1. The indexed buffer is guaranteed non-empty because it was checked at frame start and only this FSM pops it.
- Disabled channels still buffer incoming data; they are never popped in mode 1.
- flush:
  - All buffer pointers cleared, FSM to IDLE, dout_en=0 on the next cycle.
  - ovf_flag and frame_cnt are unaffected.
  - din_en in the same cycle as flush is discarded.
- Reset mid-frame: immediate return to the reset state; no partial frame completes.

Decomposition:
- Package multi_chn_frame_pkg holds:
  - mode encodings MODE_SINGLE=0, MODE_FRAME=1
  - FSM state enum {IDLE, HEADER, DATA}
  - default HDR_WORD constant
  - helper function for the next enabled index (priority scan above the current index)
- Sub-module chn_sample_buf: single-clock FIFO of DATA_W x BUF_DEPTH.
  - Inputs: push, pop, flush, din.
  - Outputs: dout (first-word-fall-through), empty, full.
  - Generated NUM_CHN times.

Test Plan:
- Mode 0, chn_sel=2, 5 samples 16'h0100..16'h0104 on din_en[2], dout_full=0 -> 5 dout_en pulses in order 0100..0104; first pulse 2 edges after the first write.
- Mode 1, chn_en=4'b1011, one sample each (ch0=A000, ch1=A001, ch3=A003) -> stream EB90, A000, A001, A003; frame_cnt=1; ch2 buffer untouched.
- Mode 1, dout_full asserted for 3 cycles after the header -> dout_en low during the stall; the frame resumes with no lost or duplicated word.
- Write 9 samples to ch1 with no drain (BUF_DEPTH=8) -> ovf_flag[1]=1 and the 9th sample dropped; ovf_clr -> flag 0. Overflow coincident with ovf_clr -> flag stays 1.
- flush asserted mid-frame (after the header) -> dout_en=0 next cycle, FSM back to IDLE, all buffers empty, frame_cnt unchanged.
- Change chn_sel and mode during a mode-1 frame -> the frame completes with the old settings; the new settings apply from the next IDLE. Also cover async reset_n pulse mid-frame -> all outputs 0.
